// File: rtl/wash_phase_timer_if.sv
// rtl/wash_phase_timer_if.sv - FSM-side bundle for the wash phase timer
interface wash_phase_timer_if;
  logic       tick;
  logic       pause;
  logic [1:0] temp_select;
  logic [1:0] cloth_type;
  logic [1:0] cycle_duration;
  logic       fill_water, wash, rinse, spin, drain, dry;
  logic       fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done;
  logic [7:0] mins_left;
  logic       busy;
  logic       phase_err;

  modport master (
    output tick, pause, temp_select, cloth_type, cycle_duration,
    output fill_water, wash, rinse, spin, drain, dry,
    input  fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done,
    input  mins_left, busy, phase_err
  );

  modport slave (
    input  tick, pause, temp_select, cloth_type, cycle_duration,
    input  fill_water, wash, rinse, spin, drain, dry,
    output fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done,
    output mins_left, busy, phase_err
  );
endinterface

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - times washing-machine phases from a programme table
module wash_phase_timer #(
  parameter int TICKS_PER_MIN = 60,
  parameter int SUB_W         = 6
) (
  input  logic              clk,
  input  logic              reset,
  wash_phase_timer_if.slave bus
);

  typedef enum logic [2:0] {
    PH_NONE, PH_FILL, PH_WASH, PH_RINSE, PH_SPIN, PH_DRAIN, PH_DRY
  } phase_e;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_MIN - 1);

  phase_e           phase_code, cur_phase_q, cur_phase_d;
  logic [7:0]       mins_left_q, mins_left_d, dur;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             phase_err_q, phase_err_d;
  logic [5:0]       phase_vec;
  logic             multi_phase;
  logic [1:0]       cyc;

  assign phase_vec   = {bus.fill_water, bus.wash, bus.rinse, bus.spin, bus.drain, bus.dry};
  assign multi_phase = (phase_vec & (phase_vec - 6'd1)) != 6'd0;
  assign cyc         = (bus.cycle_duration == 2'b11) ? 2'b00 : bus.cycle_duration;

  always_comb begin
    phase_code = PH_NONE;
    if      (bus.fill_water) phase_code = PH_FILL;
    else if (bus.wash)       phase_code = PH_WASH;
    else if (bus.rinse)      phase_code = PH_RINSE;
    else if (bus.spin)       phase_code = PH_SPIN;
    else if (bus.drain)      phase_code = PH_DRAIN;
    else if (bus.dry)        phase_code = PH_DRY;
  end

  // Programme table: columns are the 30/45/60 minute cycles.
  always_comb begin
    dur = 8'd0;
    case (phase_code)
      PH_FILL:  dur = (cyc == 2'b00) ? 8'd3  : (cyc == 2'b01) ? 8'd4  : 8'd5;
      PH_WASH:  dur = (cyc == 2'b00) ? 8'd10 : (cyc == 2'b01) ? 8'd15 : 8'd20;
      PH_RINSE: dur = (cyc == 2'b00) ? 8'd6  : (cyc == 2'b01) ? 8'd10 : 8'd13;
      PH_SPIN:  dur = (cyc == 2'b00) ? 8'd4  : (cyc == 2'b01) ? 8'd6  : 8'd8;
      PH_DRAIN: dur = (cyc == 2'b00) ? 8'd2  : (cyc == 2'b01) ? 8'd3  : 8'd4;
      PH_DRY:   dur = (cyc == 2'b00) ? 8'd5  : (cyc == 2'b01) ? 8'd7  : 8'd10;
      default:  dur = 8'd0;
    endcase
    if ((phase_code == PH_SPIN || phase_code == PH_DRY) && bus.cloth_type != 2'b00)
      dur = ((dur >> 1) == 8'd0) ? 8'd1 : (dur >> 1);
    if (phase_code == PH_FILL && bus.temp_select == 2'b10)
      dur = dur + 8'd2;
  end

  always_comb begin
    cur_phase_d = cur_phase_q;
    mins_left_d = mins_left_q;
    sub_cnt_d   = sub_cnt_q;
    phase_err_d = phase_err_q | multi_phase;
    if (phase_code == PH_NONE) begin
      cur_phase_d = PH_NONE;
      mins_left_d = 8'd0;
      sub_cnt_d   = '0;
    end else if (phase_code != cur_phase_q) begin
      // Entry (including direct jumps) reloads; config is only sampled here.
      cur_phase_d = phase_code;
      mins_left_d = dur;
      sub_cnt_d   = '0;
    end else if (mins_left_q != 8'd0 && bus.tick && !bus.pause) begin
      if (sub_cnt_q == SUB_LAST) begin
        sub_cnt_d   = '0;
        mins_left_d = mins_left_q - 8'd1;
      end else begin
        sub_cnt_d   = sub_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_phase_q <= PH_NONE;
      mins_left_q <= 8'd0;
      sub_cnt_q   <= '0;
      phase_err_q <= 1'b0;
    end else begin
      cur_phase_q <= cur_phase_d;
      mins_left_q <= mins_left_d;
      sub_cnt_q   <= sub_cnt_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign bus.fill_done  = (cur_phase_q == PH_FILL)  && (phase_code == PH_FILL)  && (mins_left_q == 8'd0);
  assign bus.wash_done  = (cur_phase_q == PH_WASH)  && (phase_code == PH_WASH)  && (mins_left_q == 8'd0);
  assign bus.rinse_done = (cur_phase_q == PH_RINSE) && (phase_code == PH_RINSE) && (mins_left_q == 8'd0);
  assign bus.spin_done  = (cur_phase_q == PH_SPIN)  && (phase_code == PH_SPIN)  && (mins_left_q == 8'd0);
  assign bus.drain_done = (cur_phase_q == PH_DRAIN) && (phase_code == PH_DRAIN) && (mins_left_q == 8'd0);
  assign bus.dry_done   = (cur_phase_q == PH_DRY)   && (phase_code == PH_DRY)   && (mins_left_q == 8'd0);
  assign bus.mins_left  = mins_left_q;
  assign bus.busy       = (cur_phase_q != PH_NONE);
  assign bus.phase_err  = phase_err_q;

endmodule
